// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - Data-bus bridge routing dmem traffic and a memory-mapped I/O page
module mem_io_bridge_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int IN_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_tvalid,
    input  logic [IN_W-1:0]               s_tdata,
    output logic                          s_tready,
    input  logic                          pop,
    output logic [IN_W-1:0]               head,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [IN_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            push;
    logic            pop_ok;

    assign s_tready = reset & (count != FULL_CNT);
    assign push     = s_tvalid & s_tready;
    // A pop on an empty queue is dropped even if a push lands on the same edge.
    assign pop_ok   = pop & (count != '0);
    assign head     = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_io_bridge #(
    parameter int          FIFO_DEPTH = 16,
    parameter int          IN_W       = 8,
    parameter logic [15:0] IO_PAGE    = 16'h1003
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            mem_wr,
    input  logic [31:0]     mem_addr,
    input  logic [31:0]     mem_writedata,
    output logic [31:0]     mem_readdata,
    output logic            dmem_wr,
    input  logic [31:0]     dmem_readdata,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    output logic [15:0]     leds
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] REG_FIFO_DATA = 2'd0;
    localparam logic [1:0] REG_FIFO_STAT = 2'd1;
    localparam logic [1:0] REG_LED       = 2'd2;
    localparam logic [1:0] REG_CYCLES    = 2'd3;

    logic            io_sel;
    logic            mapped;
    logic [1:0]      reg_sel;
    logic            io_wr;
    logic            pop;
    logic [IN_W-1:0] head;
    logic [CW-1:0]   count;
    logic [31:0]     cycles;
    logic [31:0]     stat;
    logic [31:0]     io_rdata;
    logic            unused_bits;

    assign io_sel  = (mem_addr[31:16] == IO_PAGE);
    assign mapped  = (mem_addr[15:4] == 12'h000);
    assign reg_sel = mem_addr[3:2];
    assign io_wr   = mem_wr & enable & io_sel & mapped;
    assign pop     = io_wr & (reg_sel == REG_FIFO_DATA);
    assign dmem_wr = mem_wr & enable & ~io_sel;

    // Byte lanes and upper store bits have no meaning inside the I/O page.
    assign unused_bits = ^{mem_addr[1:0], mem_writedata[31:16]};

    mem_io_bridge_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .IN_W       (IN_W)
    ) u_in_fifo (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (in_valid),
        .s_tdata  (in_data),
        .s_tready (in_ready),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    assign stat = {15'b0, 9'(count), 6'b0, (count == FULL_CNT), (count == '0)};

    always_comb begin
        io_rdata = '0;
        if (mapped) begin
            case (reg_sel)
                REG_FIFO_DATA: io_rdata = 32'(head);
                REG_FIFO_STAT: io_rdata = stat;
                REG_LED:       io_rdata = {16'b0, leds};
                REG_CYCLES:    io_rdata = cycles;
                default:       io_rdata = '0;
            endcase
        end
    end

    assign mem_readdata = io_sel ? io_rdata : dmem_readdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds <= '0;
        end else if (io_wr && reg_sel == REG_LED) begin
            leds <= mem_writedata[15:0];
        end
    end

    // Clear takes priority over the increment on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (io_wr && reg_sel == REG_CYCLES) begin
            cycles <= '0;
        end else if (enable) begin
            cycles <= cycles + 32'd1;
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - Directed-vector bench for mem_io_bridge
module tb_mem_io_bridge;
    localparam logic [31:0] A_DATA = 32'h1003_0000;
    localparam logic [31:0] A_STAT = 32'h1003_0004;
    localparam logic [31:0] A_LED  = 32'h1003_0008;
    localparam logic [31:0] A_CYC  = 32'h1003_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_writedata = '0;
    logic [31:0] mem_readdata;
    logic        dmem_wr;
    logic [31:0] dmem_readdata;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic [15:0] leds;

    logic [31:0] dmem [256];

    int n_vec = 0;
    int n_miscompares = 0;

    mem_io_bridge #(
        .FIFO_DEPTH (16),
        .IN_W       (8),
        .IO_PAGE    (16'h1003)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .dmem_wr       (dmem_wr),
        .dmem_readdata (dmem_readdata),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .leds          (leds)
    );

    always #5 clk = ~clk;

    assign dmem_readdata = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (dmem_wr) begin
            dmem[mem_addr[9:2]] <= mem_writedata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        mem_wr   = 1'b0;
        mem_addr = addr;
        #1;
        check_eq(tag, mem_readdata, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        mem_wr        = 1'b1;
        mem_addr      = addr;
        mem_writedata = data;
        step();
        mem_wr = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;

        // 1. reset then idle
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'h0);
        check_eq("rst_leds", 32'(leds), 32'h0);
        reset = 1'b1;
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 32'h1);
        repeat (5) step();
        expect_rd("cycles_5", A_CYC, 32'd5);
        expect_rd("stat_idle", A_STAT, 32'h0000_0001);
        expect_rd("led_idle", A_LED, 32'h0);
        wr(A_CYC, 32'h0);
        expect_rd("cycles_clr", A_CYC, 32'd0);
        step();
        expect_rd("cycles_after_clr", A_CYC, 32'd1);

        // 2. dmem pass-through
        mem_wr = 1'b1; mem_addr = 32'h1001_0004; mem_writedata = 32'hDEAD_BEEF;
        #1;
        check_eq("dmem_wr_store", 32'(dmem_wr), 32'h1);
        step();
        mem_wr = 1'b0;
        expect_rd("dmem_load", 32'h1001_0004, 32'hDEAD_BEEF);
        mem_wr = 1'b1; mem_addr = A_LED; mem_writedata = 32'h0000_A5A5;
        #1;
        check_eq("dmem_wr_io", 32'(dmem_wr), 32'h0);
        step();
        mem_wr = 1'b0;
        expect_rd("led_a5a5", A_LED, 32'h0000_A5A5);
        check_eq("leds_port", 32'(leds), 32'h0000_A5A5);
        expect_rd("unmapped_rd", 32'h1003_0010, 32'h0);
        wr(32'h1003_0018, 32'h0000_FFFF);
        expect_rd("unmapped_wr", A_LED, 32'h0000_A5A5);

        // 3. FIFO fill
        for (int i = 1; i <= 16; i++) push(8'(i));
        expect_rd("stat_full", A_STAT, 32'h0000_1002);
        check_eq("full_in_ready", 32'(in_ready), 32'h0);
        expect_rd("full_head", A_DATA, 32'h01);
        in_valid = 1'b1; in_data = 8'h11;
        step();
        in_valid = 1'b0;
        expect_rd("stat_held_off", A_STAT, 32'h0000_1002);
        wr(A_DATA, 32'h0);
        check_eq("pop_in_ready", 32'(in_ready), 32'h1);
        expect_rd("pop_head", A_DATA, 32'h02);
        expect_rd("stat_15", A_STAT, 32'h0000_0F00);
        for (int i = 0; i < 15; i++) begin
            expect_rd("drain", A_DATA, 32'(2 + i));
            wr(A_DATA, 32'h0);
        end
        expect_rd("stat_drained", A_STAT, 32'h0000_0001);

        // 4. order and wrap-around
        for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
        for (int i = 0; i < 10; i++) wr(A_DATA, 32'h0);
        for (int i = 0; i < 10; i++) push(8'(8'hB0 + i));
        expect_rd("stat_wrap_full", A_STAT, 32'h0000_1002);
        for (int i = 0; i < 16; i++) begin
            expect_rd("wrap_order", A_DATA, (i < 6) ? 32'(8'hAA + i) : 32'(8'hB0 + i - 6));
            wr(A_DATA, 32'h0);
        end
        expect_rd("stat_wrap_empty", A_STAT, 32'h0000_0001);

        // 5. simultaneous events
        in_valid = 1'b1; in_data = 8'h55;
        wr(A_DATA, 32'h0);
        in_valid = 1'b0;
        expect_rd("empty_pushpop_stat", A_STAT, 32'h0000_0100);
        expect_rd("empty_pushpop_data", A_DATA, 32'h55);
        push(8'h66);
        push(8'h77);
        in_valid = 1'b1; in_data = 8'h88;
        wr(A_DATA, 32'h0);
        in_valid = 1'b0;
        expect_rd("cnt3_pushpop_stat", A_STAT, 32'h0000_0300);
        expect_rd("cnt3_pushpop_head", A_DATA, 32'h66);
        for (int i = 0; i < 3; i++) wr(A_DATA, 32'h0);
        wr(A_DATA, 32'h0);
        expect_rd("pop_empty_stat", A_STAT, 32'h0000_0001);
        expect_rd("pop_empty_data", A_DATA, 32'h0);

        // 6. enable and reset
        wr(A_CYC, 32'h0);
        enable = 1'b0;
        wr(A_LED, 32'h0000_1234);
        expect_rd("en0_led", A_LED, 32'h0000_A5A5);
        repeat (3) step();
        expect_rd("en0_cycles", A_CYC, 32'd0);
        mem_wr = 1'b1; mem_addr = 32'h1001_0008; mem_writedata = 32'h1;
        #1;
        check_eq("en0_dmem_wr", 32'(dmem_wr), 32'h0);
        mem_wr = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) push(8'(i));
        enable = 1'b0;
        wr(A_DATA, 32'h0);
        expect_rd("en0_pop_ignored", A_STAT, 32'h0000_0500);
        enable = 1'b1;
        in_valid = 1'b1; in_data = 8'h99;
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_in_ready", 32'(in_ready), 32'h0);
        check_eq("rst_mid_leds", 32'(leds), 32'h0);
        expect_rd("rst_mid_stat", A_STAT, 32'h0000_0001);
        expect_rd("rst_mid_cycles", A_CYC, 32'h0);
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check_eq("rel2_in_ready", 32'(in_ready), 32'h1);
        expect_rd("rel2_stat", A_STAT, 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompares);
        $finish;
    end
endmodule
